// File: rtl/wb_dcache_victim_buffer.sv
// Fully-associative victim buffer beside the write-back dcache.
// Catches evicted dcache lines and answers the controller's miss lookup, so a
// recently evicted line can be swapped back without a memory round trip.
// Has a single-entry write-back path for dirty lines it displaces, plus a full flush.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   lookup_req_i/addr   lookup strobe and line address
//   victim_hit_o/line/dirty  registered lookup result (snapshot of hit entry)
//   take_i              controller consumes the hit entry
//   insert_i/addr/line/dirty  evicted dcache line; insert_ready_o accepts it
//   kill_i              drops the pending lookup result
//   flush_i             start flush; flush_done_o pulses on completion
//   vc2mem_*            write-back request (writes only); mem2vc_ack_i accepts it
module wb_dcache_victim_buffer #(
  parameter int unsigned VC_ENTRIES = 4,
  parameter int unsigned LADDR_BITS = 28,
  parameter int unsigned LINE_BITS  = 128
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  lookup_req_i,
  input  logic [LADDR_BITS-1:0] lookup_addr_i,
  output logic                  victim_hit_o,
  output logic [LINE_BITS-1:0]  victim_line_o,
  output logic                  victim_dirty_o,
  input  logic                  take_i,
  input  logic                  insert_i,
  input  logic [LADDR_BITS-1:0] insert_addr_i,
  input  logic [LINE_BITS-1:0]  insert_line_i,
  input  logic                  insert_dirty_i,
  output logic                  insert_ready_o,
  input  logic                  kill_i,
  input  logic                  flush_i,
  output logic                  flush_done_o,
  output logic                  vc2mem_req_o,
  output logic                  vc2mem_wr_o,
  output logic [LADDR_BITS-1:0] vc2mem_addr_o,
  output logic [LINE_BITS-1:0]  vc2mem_data_o,
  input  logic                  mem2vc_ack_i
);

  localparam int unsigned IDX_W = $clog2(VC_ENTRIES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(VC_ENTRIES - 1);

  typedef enum logic [2:0] {
    VC_IDLE,
    VC_WB,
    VC_FLUSH,
    VC_FLUSH_WB,
    VC_FLUSH_DONE
  } state_t;

  state_t state, state_d;

  // Entry storage
  logic [VC_ENTRIES-1:0] valid;
  logic [VC_ENTRIES-1:0] dirty;
  logic [LADDR_BITS-1:0] ent_addr [VC_ENTRIES];
  logic [LINE_BITS-1:0]  ent_line [VC_ENTRIES];

  logic [IDX_W-1:0]      fifo_ptr;
  logic [IDX_W-1:0]      hit_idx;
  logic [IDX_W-1:0]      scan_idx;
  logic                  flush_pend;
  logic [LADDR_BITS-1:0] wb_addr;
  logic [LINE_BITS-1:0]  wb_data;

  // Associative search results
  logic             lk_match;
  logic [IDX_W-1:0] lk_idx;
  logic             in_match;
  logic [IDX_W-1:0] in_idx;
  logic             free_found;
  logic [IDX_W-1:0] free_idx;

  // Per-cycle control decoded by the FSM
  logic             ins_fire;
  logic             take_fire;
  logic             ins_merge;
  logic             ins_evict;
  logic             evict_wb;
  logic [IDX_W-1:0] ins_idx;
  logic             flush_copy;
  logic             flush_clear;
  logic             lk_ok;
  logic             flush_next;

  // Lowest-index match / free slot: scan downwards so the lowest index wins
  always_comb begin
    lk_match   = 1'b0;
    lk_idx     = '0;
    in_match   = 1'b0;
    in_idx     = '0;
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = int'(VC_ENTRIES) - 1; i >= 0; i--) begin
      if (valid[i] && (ent_addr[i] == lookup_addr_i)) begin
        lk_match = 1'b1;
        lk_idx   = IDX_W'(i);
      end
      if (valid[i] && (ent_addr[i] == insert_addr_i)) begin
        in_match = 1'b1;
        in_idx   = IDX_W'(i);
      end
      if (!valid[i]) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
  end

  // Next-state and control decode
  always_comb begin
    state_d        = state;
    insert_ready_o = (state == VC_IDLE) && !flush_i;
    ins_fire       = insert_i && insert_ready_o;
    take_fire      = take_i && victim_hit_o;
    ins_merge      = 1'b0;
    ins_evict      = 1'b0;
    evict_wb       = 1'b0;
    ins_idx        = fifo_ptr;
    flush_copy     = 1'b0;
    flush_clear    = 1'b0;

    // Slot selection: swap > same-address merge > free slot > FIFO victim
    if (ins_fire) begin
      if (take_fire) begin
        ins_idx = hit_idx;
      end else if (in_match) begin
        ins_merge = 1'b1;
        ins_idx   = in_idx;
      end else if (free_found) begin
        ins_idx = free_idx;
      end else begin
        ins_evict = 1'b1;
        ins_idx   = fifo_ptr;
        evict_wb  = dirty[fifo_ptr];
      end
    end

    case (state)
      VC_IDLE: begin
        if (flush_i) begin
          state_d = VC_FLUSH;
        end else if (evict_wb) begin
          state_d = VC_WB;
        end
      end
      VC_WB: begin
        if (mem2vc_ack_i) begin
          state_d = (flush_pend || flush_i) ? VC_FLUSH : VC_IDLE;
        end
      end
      VC_FLUSH: begin
        if (valid[scan_idx] && dirty[scan_idx]) begin
          flush_copy = 1'b1;
          state_d    = VC_FLUSH_WB;
        end else begin
          flush_clear = 1'b1;
          if (scan_idx == LAST_IDX) begin
            state_d = VC_FLUSH_DONE;
          end
        end
      end
      VC_FLUSH_WB: begin
        if (mem2vc_ack_i) begin
          state_d = (scan_idx == LAST_IDX) ? VC_FLUSH_DONE : VC_FLUSH;
        end
      end
      VC_FLUSH_DONE: state_d = VC_IDLE;
      default:       state_d = VC_IDLE;
    endcase

    lk_ok      = (state == VC_IDLE) || (state == VC_WB);
    flush_next = (state_d == VC_FLUSH) || (state_d == VC_FLUSH_WB) ||
                 (state_d == VC_FLUSH_DONE);
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= VC_IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Valid/dirty bits; later assignments override earlier ones (swap beats take)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= '0;
      dirty <= '0;
    end else begin
      if (take_fire) begin
        valid[hit_idx] <= 1'b0;
        dirty[hit_idx] <= 1'b0;
      end
      if (flush_copy || flush_clear) begin
        valid[scan_idx] <= 1'b0;
        dirty[scan_idx] <= 1'b0;
      end
      if (ins_fire) begin
        valid[ins_idx] <= 1'b1;
        dirty[ins_idx] <= ins_merge ? (dirty[ins_idx] | insert_dirty_i) : insert_dirty_i;
      end
    end
  end

  // Entry payload, qualified by the valid bits so it needs no reset
  always_ff @(posedge clk) begin
    if (ins_fire) begin
      ent_addr[ins_idx] <= insert_addr_i;
      ent_line[ins_idx] <= insert_line_i;
    end
  end

  // Replacement pointer and flush scan index
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fifo_ptr   <= '0;
      scan_idx   <= '0;
      flush_pend <= 1'b0;
    end else begin
      if (state == VC_FLUSH_DONE) begin
        fifo_ptr <= '0;
      end else if (ins_evict) begin
        fifo_ptr <= fifo_ptr + 1'b1;
      end

      if ((state_d == VC_FLUSH) && lk_ok) begin
        scan_idx <= '0;
      end else if (flush_clear || ((state == VC_FLUSH_WB) && mem2vc_ack_i)) begin
        scan_idx <= scan_idx + 1'b1;
      end

      // A flush requested during a write-back starts once it completes
      if (state == VC_WB) begin
        if (mem2vc_ack_i) begin
          flush_pend <= 1'b0;
        end else if (flush_i) begin
          flush_pend <= 1'b1;
        end
      end
    end
  end

  // Write-back holding register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_addr <= '0;
      wb_data <= '0;
    end else if (evict_wb) begin
      wb_addr <= ent_addr[fifo_ptr];
      wb_data <= ent_line[fifo_ptr];
    end else if (flush_copy) begin
      wb_addr <= ent_addr[scan_idx];
      wb_data <= ent_line[scan_idx];
    end
  end

  // Lookup result; the line/dirty outputs are a snapshot taken at lookup time
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      victim_hit_o   <= 1'b0;
      victim_line_o  <= '0;
      victim_dirty_o <= 1'b0;
      hit_idx        <= '0;
    end else begin
      if (!lk_ok || flush_next || kill_i) begin
        victim_hit_o <= 1'b0;
      end else if (lookup_req_i) begin
        victim_hit_o   <= lk_match;
        hit_idx        <= lk_idx;
        victim_line_o  <= ent_line[lk_idx];
        victim_dirty_o <= lk_match & dirty[lk_idx];
      end else if (take_fire) begin
        victim_hit_o <= 1'b0;
      end
    end
  end

  assign vc2mem_req_o  = (state == VC_WB) || (state == VC_FLUSH_WB);
  assign vc2mem_wr_o   = vc2mem_req_o;
  assign vc2mem_addr_o = wb_addr;
  assign vc2mem_data_o = wb_data;
  assign flush_done_o  = (state == VC_FLUSH_DONE);

endmodule
